lane_tick_scheduler: RTL and testbench

Derives the game frame tick from the system clock and schedules per-lane movement updates for the Frogger playfield. Each lane has a programmable period in frames. Due lanes are queued and handed one at a time, over a valid/ready handshake, to the shared object-update datapath. The block sits between the clock domain's free-running logic and the lane/object update engine.

---
 rtl/lane_tick_scheduler.sv | 75 +++++++
 tb/tb_lane_tick_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lane_tick_scheduler.sv
// lane_tick_scheduler: frame tick prescaler and per-lane update request scheduler
module lane_tick_scheduler #(
  parameter int FRAME_DIV = 834168,
  parameter int DIV_WIDTH = 21,
  parameter int LANES = 4,
  parameter int LANE_W = 2,
  parameter int PERIOD_WIDTH = 4,
  parameter int DEFAULT_PERIOD = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    period_wr,
  input  logic [LANE_W-1:0]       period_lane,
  input  logic [PERIOD_WIDTH-1:0] period_val,
  input  logic                    upd_ready,
  output logic                    upd_valid,
  output logic [LANE_W-1:0]       upd_lane,
  output logic                    frame_tick,
  output logic                    busy,
  output logic                    overrun
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nx;
  logic [DIV_WIDTH-1:0]    presc;
  logic [PERIOD_WIDTH-1:0] per [LANES];
  logic [PERIOD_WIDTH-1:0] fcnt [LANES];
  logic [LANES-1:0]        pend, pend_nx, due, clr;
  logic [LANE_W-1:0]       low;
  assign frame_tick = en && presc == DIV_WIDTH'(FRAME_DIV - 1);
  assign upd_valid = state == ISSUE;
  assign upd_lane = upd_valid ? low : '0;
  assign busy = |pend || upd_valid;
  // due lanes (a same-edge period write suppresses them), lowest pending lane, next pend set
  always_comb begin
    due = '0;
    low = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      due[i] = frame_tick && per[i] != '0 && fcnt[i] == per[i] - 1'b1 && !(period_wr && period_lane == LANE_W'(i));
      if (pend[i]) low = LANE_W'(i);
    end
    clr = (upd_valid && upd_ready) ? LANES'(1) << low : '0;
    pend_nx = (pend & ~clr) | due;
  end
  // issue FSM next state: leave ISSUE only once the accepted lane was the last one pending
  always_comb begin
    state_nx = state == IDLE ? (|pend ? ISSUE : IDLE) : ((upd_ready && pend_nx == '0) ? IDLE : ISSUE);
  end
  // prescaler, lane counters/periods, pending set, sticky overrun and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      pend <= '0;
      overrun <= 1'b0;
      state <= IDLE;
      for (int i = 0; i < LANES; i++) begin
        per[i] <= PERIOD_WIDTH'(DEFAULT_PERIOD);
        fcnt[i] <= '0;
      end
    end else begin
      if (en) presc <= frame_tick ? '0 : presc + 1'b1;
      pend <= pend_nx;
      if (|(due & pend)) overrun <= 1'b1;
      state <= state_nx;
      for (int i = 0; i < LANES; i++) begin
        if (period_wr && period_lane == LANE_W'(i)) begin
          per[i] <= period_val;
          fcnt[i] <= '0;
        end else if (frame_tick && per[i] != '0) begin
          fcnt[i] <= due[i] ? '0 : fcnt[i] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lane_tick_scheduler.sv
// tb_lane_tick_scheduler: randomized and directed checks against a behavioural model
module tb_lane_tick_scheduler;
  localparam int FD = 8;
  logic clk = 0, rst = 1, en = 0, period_wr = 0, upd_ready = 0;
  logic [1:0] period_lane = 0;
  logic [3:0] period_val = 0;
  logic upd_valid, frame_tick, busy, overrun;
  logic [1:0] upd_lane;
  int total = 0, bad = 0;
  bit chk_on = 0;
  int presc_m, per_m[4], since[4];
  logic [3:0] pend_m;
  logic valid_m, ovr_m;

  lane_tick_scheduler #(.FRAME_DIV(FD), .DIV_WIDTH(3), .LANES(4), .LANE_W(2),
    .PERIOD_WIDTH(4), .DEFAULT_PERIOD(1)) dut (
    .clk(clk), .rst(rst), .en(en), .period_wr(period_wr), .period_lane(period_lane),
    .period_val(period_val), .upd_ready(upd_ready), .upd_valid(upd_valid),
    .upd_lane(upd_lane), .frame_tick(frame_tick), .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  function automatic int lowest(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", n, $time, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // model: a lane is due on every tick that completes a multiple of its period since its last write
  always @(posedge clk) begin
    logic [3:0] nxt;
    logic t;
    if (rst) begin
      presc_m = 0;
      pend_m = 0;
      valid_m = 0;
      ovr_m = 0;
      for (int i = 0; i < 4; i++) begin
        per_m[i] = 1;
        since[i] = 0;
      end
    end else begin
      t = en && presc_m == FD - 1;
      nxt = pend_m;
      if (valid_m && upd_ready) nxt[lowest(pend_m)] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (period_wr && period_lane == i) begin
          per_m[i] = period_val;
          since[i] = 0;
        end else if (t) begin
          since[i]++;
          if (per_m[i] != 0 && since[i] % per_m[i] == 0) begin
            if (pend_m[i]) ovr_m = 1;
            nxt[i] = 1'b1;
          end
        end
      end
      valid_m = valid_m ? nxt != 0 : pend_m != 0;
      pend_m = nxt;
      if (en) presc_m = (presc_m + 1) % FD;
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) if (chk_on) begin
    chk("frame_tick", frame_tick, en && presc_m == FD - 1);
    chk("upd_valid", upd_valid, valid_m);
    chk("upd_lane", upd_lane, valid_m ? lowest(pend_m) : 0);
    chk("busy", busy, pend_m != 0 || valid_m);
    chk("overrun", overrun, ovr_m);
  end

  initial begin
    step();
    step();
    chk_on = 1;
    rst = 0; en = 1; upd_ready = 1;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      chk("lit_tick", frame_tick, (c == 7 || c == 15));
      if (c >= 8 && c <= 13) chk("lit_valid", upd_valid, (c >= 9 && c <= 12));
      if (c >= 9 && c <= 12) chk("lit_lane", upd_lane, c - 9);
      chk("lit_ovr", overrun, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      period_wr = 1; period_lane = 2'(i); period_val = 4'((i + 1) % 4);
    end
    step();
    period_wr = 0;
    repeat (6 * FD + 4) step();
    rst = 1;
    step();
    rst = 0; upd_ready = 0;
    repeat (20) step();
    @(negedge clk);
    chk("lit_hold_lane", upd_lane, 0);
    chk("lit_overrun", overrun, 1);
    step();
    upd_ready = 1;
    repeat (8) step();
    for (int k = 0; k < 20 && presc_m != 5; k++) step();
    chk("wait_presc5", presc_m, 5);
    en = 0;
    repeat (10) step();
    en = 1;
    repeat (4) step();
    for (int k = 0; k < 20 && presc_m != FD - 1; k++) step();
    chk("wait_tick", presc_m, FD - 1);
    period_wr = 1; period_lane = 1; period_val = 2;
    step();
    period_wr = 0;
    repeat (3 * FD) step();
    upd_ready = 0;
    for (int k = 0; k < 30 && !valid_m; k++) step();
    chk("wait_valid", valid_m, 1);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("lit_rst_valid", upd_valid, 0);
    chk("lit_rst_busy", busy, 0);
    step();
    repeat (2000) begin
      step();
      en = $urandom % 8 != 0;
      upd_ready = $urandom % 3 != 0;
      period_wr = $urandom % 10 == 0;
      period_lane = 2'($urandom % 4);
      period_val = 4'($urandom % 4);
      rst = $urandom % 300 == 0;
    end
    step();
    rst = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
